// File: rtl/moving_average_stream_source_if.sv
// Valid/ready sample stream carried into the moving-average block.
// master = transmitter (drives data/valid), slave = receiver (drives ready).
interface moving_average_stream_source_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/moving_average_stream_source.sv
// Programmable stream sample source: constant, ramp or Galois-LFSR pattern,
// a configured number of beats per start pulse, with backpressure and abort.
module moving_average_stream_source #(
    parameter int              DATA_W    = 64,
    parameter int              CNT_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(64'hD800000000000000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    moving_average_stream_source_if.master datastrm,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_RAMP = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] step_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  rem_q;
    logic              abort_pend_q;
    logic              aborted_q;
    logic [CNT_W-1:0]  sent_q;

    logic hs;
    logic last_beat;
    logic abort_eff;

    function automatic logic [DATA_W-1:0] first_sample(input logic [1:0] m,
                                                       input logic [DATA_W-1:0] b);
        // An all-zero LFSR state would lock up, so seed it with 1 instead.
        if (m == MODE_LFSR && b == '0)
            return DATA_W'(1);
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] next_sample(input logic [1:0] m,
                                                      input logic [DATA_W-1:0] d,
                                                      input logic [DATA_W-1:0] s);
        case (m)
            MODE_RAMP: return d + s;
            MODE_LFSR: return (d >> 1) ^ (d[0] ? LFSR_POLY : '0);
            default:   return d;
        endcase
    endfunction

    assign hs        = (state_q == S_RUN) && datastrm.ready;
    assign last_beat = (rem_q == CNT_W'(1));
    // Abort seen in the same cycle as a handshake ends the run on that beat.
    assign abort_eff = abort_pend_q | abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (hs && (last_beat || abort_eff))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q       <= '0;
            step_q       <= '0;
            data_q       <= '0;
            rem_q        <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            sent_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q       <= mode;
                        step_q       <= step;
                        rem_q        <= count;
                        data_q       <= first_sample(mode, base);
                        sent_q       <= '0;
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort)
                        abort_pend_q <= 1'b1;
                    if (hs) begin
                        if (sent_q != '1)
                            sent_q <= sent_q + CNT_W'(1);
                        rem_q  <= rem_q - CNT_W'(1);
                        data_q <= next_sample(mode_q, data_q, step_q);
                        if (last_beat || abort_eff) begin
                            aborted_q    <= abort_eff;
                            abort_pend_q <= 1'b0;
                        end
                    end
                end
                S_DONE:  abort_pend_q <= 1'b0;
                default: abort_pend_q <= 1'b0;
            endcase
        end
    end

    assign datastrm.data  = data_q;
    assign datastrm.valid = (state_q == S_RUN);
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign aborted        = aborted_q;
    assign sent           = sent_q;

endmodule

// File: tb/tb_moving_average_stream_source.sv
// Scoreboard bench: stimulus pushes model samples, a negedge monitor pops
// and compares every handshaken beat and checks hold-under-backpressure.
module tb_moving_average_stream_source;

    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 16;
    localparam logic [63:0] POLY   = 64'hD800000000000000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] base = '0;
    logic [DATA_W-1:0] step = '0;
    logic [CNT_W-1:0]  count = '0;
    logic              busy, done, aborted;
    logic [CNT_W-1:0]  sent;

    moving_average_stream_source_if #(.DATA_W(DATA_W)) dstrm ();

    moving_average_stream_source #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .LFSR_POLY(POLY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .base    (base),
        .step    (step),
        .count   (count),
        .abort   (abort),
        .datastrm(dstrm),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .sent    (sent)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q[$];
    int          rmode = 0;      // 0 always ready, 1 random, 2 manual, 3 pattern
    logic        ready_man = 1'b1;
    logic        rpat[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ready driver, offset from the stimulus so mode changes are race-free.
    initial begin
        dstrm.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: dstrm.ready = 1'b1;
                1: dstrm.ready = 1'($urandom_range(0, 1));
                2: dstrm.ready = ready_man;
                default: dstrm.ready = (rpat.size() != 0) ? rpat.pop_front() : 1'b1;
            endcase
        end
    end

    initial begin : monitor
        logic        pv, pr;
        logic [63:0] pd;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", 64'(dstrm.valid), 64'd1);
                    check("hold_data", dstrm.data, pd);
                end
                if (dstrm.valid && dstrm.ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", dstrm.data);
                    end else begin
                        check("beat_data", dstrm.data, exp_q.pop_front());
                    end
                end
                pv = dstrm.valid;
                pr = dstrm.ready;
                pd = dstrm.data;
            end
        end
    end

    task automatic push_model(input logic [1:0] m, input logic [63:0] b,
                              input logic [63:0] s, input int n);
        logic [63:0] x;
        x = (m == 2'd2 && b == 64'd0) ? 64'd1 : b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(x);
            case (m)
                2'd1: x = x + s;
                2'd2: x = (x >> 1) ^ (x[0] ? POLY : 64'd0);
                default: ;
            endcase
        end
    endtask

    // Called one step after the edge that sampled start.
    task automatic wait_done(input int exp_sent, input logic exp_ab, input int exp_cycles);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
            return;
        end
        if (exp_cycles >= 0)
            check("done_latency", 64'(n), 64'(exp_cycles));
        check("sent", 64'(sent), 64'(exp_sent));
        check("aborted", 64'(aborted), 64'(exp_ab));
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(dstrm.valid), 64'd0);
        check("beats_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        check("aborted_hold", 64'(aborted), 64'(exp_ab));
        check("sent_hold", 64'(sent), 64'(exp_sent));
    endtask

    task automatic run(input logic [1:0] m, input logic [63:0] b, input logic [63:0] s,
                       input int c, input int rm);
        push_model(m, b, s, c);
        @(posedge clk);
        #1;
        mode = m; base = b; step = s; count = CNT_W'(c); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rmode = rm;
        check("start_valid", 64'(dstrm.valid), 64'(c != 0));
        check("start_busy", 64'(busy), 64'(c != 0));
        wait_done(c, 1'b0, (rm == 0) ? c : -1);
        rmode = 0;
    endtask

    initial begin
        #23;
        check("rst_valid", 64'(dstrm.valid), 64'd0);
        check("rst_data", dstrm.data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_sent", 64'(sent), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run(2'd1, 64'd10, 64'd5, 4, 0);
        rpat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run(2'd0, 64'hAA, 64'd0, 3, 3);
        run(2'd2, 64'd0, 64'd0, 3, 0);
        run(2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2, 0);

        // Abort while beat 2 is stalled; a start during RUN must be ignored.
        push_model(2'd1, 64'd100, 64'd1, 2);
        @(posedge clk);
        #1;
        mode = 2'd1; base = 64'd100; step = 64'd1; count = 16'd10; start = 1'b1;
        ready_man = 1'b1;
        rmode = 2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        ready_man = 1'b0; abort = 1'b1; start = 1'b1; base = 64'd999; count = 16'd1;
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("abort_hold_valid", 64'(dstrm.valid), 64'd1);
        check("abort_hold_data", dstrm.data, 64'd101);
        ready_man = 1'b1;
        wait_done(2, 1'b1, -1);
        rmode = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("no_queued_start", 64'(busy), 64'd0);

        run(2'd0, 64'd5, 64'd0, 0, 0);

        // Asynchronous reset mid-run.
        push_model(2'd1, 64'd1000, 64'd2, 50);
        @(posedge clk);
        #1;
        mode = 2'd1; base = 64'd1000; step = 64'd2; count = 16'd50; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(dstrm.valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sent", 64'(sent), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(2'd1, 64'd7, 64'd1, 3, 0);

        for (int i = 0; i < 25; i++) begin
            logic [63:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            run(2'($urandom_range(0, 3)), rb, {$urandom, $urandom},
                int'($urandom_range(0, 12)), int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
